// File: rtl/fetch_pkg.sv
// Shared encodings and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam int          FETCH_BUF_DEPTH = 2;
  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam int          DATA_W          = 64;

  // One buffered fetch: the PC it came from and the word returned there.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, instr} pairs; entry 0 is always the head.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DATA_W = fetch_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  localparam logic [1:0] FULL = 2'(FETCH_BUF_DEPTH);

  logic [DATA_W-1:0] ent0;
  logic [DATA_W-1:0] ent1;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != FULL) || pop_ok);
  assign head    = ent0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + 2'd1;
    end else if (pop_ok && !push_ok) begin
      count <= count - 2'd1;
    end
  end

  // Payload carries no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (pop_ok) begin
        if (push_ok && count == 2'd1) begin
          ent0 <= din;
        end else begin
          ent0 <= ent1;
          if (push_ok) ent1 <= din;
        end
      end else if (push_ok) begin
        if (count == 2'd0) ent0 <= din;
        else               ent1 <= din;
      end
    end
  end

endmodule

// File: rtl/program_memory.sv
// Combinational instruction ROM: each word is a fixed scramble of its address.
module program_memory (
  input  logic [31:0] pc,
  output logic [31:0] instr_out
);

  assign instr_out = {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, streams instruction words into a 2-entry
// buffer toward decode, and handles redirects and misaligned-target faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        debug,
  input  logic        enable,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fault
);

  localparam logic [1:0] BUF_FULL = 2'(FETCH_BUF_DEPTH);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         redirect;
  logic         misaligned;
  logic         buf_valid;
  logic         pop;
  logic         push;
  logic         unused_debug;

  assign unused_debug = debug;

  // A redirect in FAULT is ignored; otherwise it overrides push and pop.
  assign redirect   = redirect_valid && (state_q != ST_FAULT);
  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
  assign buf_valid  = (count != 2'd0) && (state_q != ST_FAULT);
  assign pop        = buf_valid && out_ready && !redirect;
  assign push       = (state_q == ST_FETCH) && ((count != BUF_FULL) || pop) && !redirect;

  assign push_entry = '{pc: pc_q, instr: imem_data};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE:  if (enable)  state_d = ST_FETCH;
      ST_FETCH: if (!enable) state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    if (redirect) begin
      state_d = misaligned ? ST_FAULT : state_q;
      if (!misaligned) pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign imem_addr = pc_q;
  assign out_valid = buf_valid;
  assign out_instr = buf_valid ? head.instr : 32'd0;
  assign out_pc    = buf_valid ? head.pc    : 32'd0;
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with program_memory; directed scenarios plus random traffic.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        debug;
  logic        enable;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: queue of buffered PCs, next fetch PC, fetch/fault flags.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_fetch;
  bit          m_fault;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .debug          (debug),
    .enable         (enable),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fault          (fault)
  );

  program_memory u_mem (
    .pc        (imem_addr),
    .instr_out (imem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_pc();
    return (m_q.size() != 0) ? m_q[0] : 32'd0;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (m_q.size() != 0) ? mem_word(m_q[0]) : 32'd0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc    = 32'd0;
    m_fetch = 1'b0;
    m_fault = 1'b0;
  endtask

  // Drive one cycle's inputs, advance the model through the edge, return at negedge.
  task automatic cycle(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
    bit pop;
    bit push;
    enable         = en;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    if (rv && !m_fault) begin
      m_q.delete();
      if (rpc[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_fetch = 1'b0;
      end else begin
        m_pc = rpc;
      end
    end else if (!m_fault) begin
      pop  = rdy && (m_q.size() != 0);
      push = m_fetch && ((m_q.size() < 2) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      m_fetch = en;
    end
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    rst            = 1'b1;
    enable         = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_tests++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_tests++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] want;
    apply_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      want = 32'(i * 4);
      n_tests++; if (out_pc !== want) begin n_fail++; $display("FAIL stream_pc%0d: got %h want %h", i, out_pc, want); end
      n_tests++; if (out_instr !== mem_word(want)) begin n_fail++; $display("FAIL stream_instr%0d: got %h want %h", i, out_instr, mem_word(want)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    apply_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_addr: got %h want 00000008", imem_addr); end
    n_tests++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head: got %h/%b want 00000000/1", out_pc, out_valid); end
    for (int i = 0; i < 4; i++) begin
      want = 32'(i * 4);
      n_tests++; if (out_pc !== want || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain%0d: got %h want %h", i, out_pc, want); end
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
    end
  endtask

  task automatic test_redirect_full();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h10);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %b want 0", out_valid); end
    n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL redir_addr: got %h want 00000010", imem_addr); end
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_pc !== 32'h10 || out_instr !== mem_word(32'h10)) begin n_fail++; $display("FAIL redir_head0: got %h want 00000010", out_pc); end
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_pc !== 32'h14) begin n_fail++; $display("FAIL redir_head1: got %h want 00000014", out_pc); end
  endtask

  task automatic test_misaligned();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h06);
    n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b want 1", fault); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b want 0", out_valid); end
    n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL mis_addr: got %h want 00000008", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'(i == 1), 32'h20);
      n_tests++; if (fault !== 1'b1 || imem_addr !== 32'h8 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_sticky%0d: got %b/%h/%b want 1/00000008/0", i, fault, imem_addr, out_valid); end
    end
    apply_reset();
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", fault); end
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mis_restart: got %h/%b want 00000000/1", out_pc, out_valid); end
  endtask

  task automatic test_wrap_drain();
    apply_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    n_tests++; if (out_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_head0: got %h want fffffffc", out_pc); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr_mod: got %h want 00000000", imem_addr); end
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_head1: got %h/%b want 00000000/1", out_pc, out_valid); end
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_valid !== 1'b0 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL drain_idle: got %b/%h want 0/00000004", out_valid, imem_addr); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin n_fail++; $display("FAIL async_out: got %b/%h/%h want 0/0/0", out_valid, out_pc, out_instr); end
    n_tests++; if (imem_addr !== 32'd0 || fault !== 1'b0) begin n_fail++; $display("FAIL async_addr: got %h/%b want 0/0", imem_addr, fault); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_stale: got %b want 0", out_valid); end
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    n_tests++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL async_restart: got %h/%b want 00000000/1", out_pc, out_valid); end
  endtask

  task automatic test_random();
    logic        en;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 5) != 0);
      rdy = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 9) == 0);
      rpc = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
      if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cycle(en, rdy, rv, rpc);
      n_tests++; if (out_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, out_valid, (m_q.size() != 0)); end
      n_tests++; if (out_pc !== exp_pc()) begin n_fail++; $display("FAIL rnd_pc@%0d: got %h want %h", i, out_pc, exp_pc()); end
      n_tests++; if (out_instr !== exp_instr()) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h want %h", i, out_instr, exp_instr()); end
      n_tests++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, m_pc); end
      n_tests++; if (fault !== m_fault) begin n_fail++; $display("FAIL rnd_fault@%0d: got %b want %b", i, fault, m_fault); end
      if (m_fault && $urandom_range(0, 3) == 0) apply_reset();
    end
  endtask

  initial begin
    rst            = 1'b0;
    debug          = 1'b0;
    enable         = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_wrap_drain();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
